ro_meas_sequencer: RTL

- Single-clock measurement sequencer that sits directly upstream and downstream of the ring-oscillator counter.
- It drives the counter's enable with a precisely timed gate window and samples the 15-bit count once it is frozen.
- It computes the delta count for the window and transmits it on a UART 8N1 line, so the oscillator frequency can be read with one pin.
- The count input belongs to the oscillator domain. It is read only while the gate is low and after a settle delay, when it is static.

---
 rtl/ro_meas_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ro_meas_sequencer.sv
// rtl/ro_meas_sequencer.sv - ring-oscillator gate/settle/sample sequencer with 8N1 UART report
//
// Purpose: opens a timed enable window on the oscillator counter, waits for the
// count to settle, and samples the frozen count. It then reports the 15-bit delta
// as three UART 8N1 bytes: 0xA5, {0,delta[14:8]}, delta[7:0].
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     level; high while idle launches a measurement
//   gate_sel  window exponent offset, latched at start
//   count_in  oscillator count, only read while gate_en is low and settled
//   gate_en   enable to the oscillator counter
//   tx        UART line, idle high
//   busy      high whenever a measurement or frame is in progress
//   done      one-cycle pulse at the end of the last stop bit
//   result    last delta count, held until the next capture
module ro_meas_sequencer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SETTLE       = 8,
    parameter int GATE_BASE    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  gate_sel,
    input  logic [14:0] count_in,
    output logic        gate_en,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [14:0] result
);

    // One counter serves settle, window and baud timing; it must hold W-1 for gate_sel=7.
    localparam int CNT_W = (GATE_BASE + 8 > 18) ? GATE_BASE + 8 : 18;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_GATE, S_POST, S_TX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [14:0]        base_q, base_d;
    logic [14:0]        result_q, result_d;
    logic [28:0]        shift_q, shift_d;
    logic [4:0]         bit_q, bit_d;
    logic               gate_en_q, gate_en_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   win_last;
    logic               settle_end, win_end, baud_end, last_bit;
    logic [14:0]        delta;
    logic [28:0]        frame_tail;

    assign win_last   = (CNT_W'(1) << (GATE_BASE + int'(sel_q))) - CNT_W'(1);
    assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
    assign win_end    = (cnt_q == win_last);
    assign baud_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_q == 5'd29);

    // Modular subtraction absorbs counter wrap-around.
    assign delta = count_in - base_q;

    // The 30-bit frame minus its leading start bit, which is driven directly on entry to TX.
    assign frame_tail = {1'b1, delta[7:0], 1'b0,
                         1'b1, 1'b0, delta[14:8], 1'b0,
                         1'b1, 8'hA5};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)                 state_d = S_PRE;
            S_PRE:  if (settle_end)            state_d = S_GATE;
            S_GATE: if (win_end)               state_d = S_POST;
            S_POST: if (settle_end)            state_d = S_TX;
            S_TX:   if (baud_end && last_bit)  state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output is taken from a register.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        sel_d     = sel_q;
        base_d    = base_q;
        result_d  = result_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        gate_en_d = gate_en_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    sel_d  = gate_sel;
                    busy_d = 1'b1;
                end
            end
            S_PRE: begin
                if (settle_end) begin
                    base_d    = count_in;
                    gate_en_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            S_GATE: begin
                if (win_end) begin
                    gate_en_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_POST: begin
                if (settle_end) begin
                    result_d = delta;
                    tx_d     = 1'b0;
                    shift_d  = frame_tail;
                    bit_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_TX: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        tx_d   = 1'b1;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[28:1]};
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sel_q     <= '0;
            base_q    <= '0;
            result_q  <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            gate_en_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            base_q    <= base_d;
            result_q  <= result_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            gate_en_q <= gate_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign gate_en = gate_en_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule
